// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the blocks that sequence it:
// ALU operation codes, flag bit positions and the multiplier sequencer states.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  // ALU operation select codes
  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_AND    = 3'd2;
  localparam logic [2:0] ALU_LSHIFT = 3'd3;

  // Bit positions inside a result-flag vector
  localparam int ZERO = 0;
  localparam int SIGN = 1;
  localparam int FLAG_W = 2;

  // Multiplier sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seqStateT;

endpackage

// File: rtl/alu_mul_sequencer_alu.sv
// Purely combinational ALU shared by the execute stage and the multiplier
// sequencer. The operation is chosen by AluControl; shifts use the low five
// bits of scrB as the shift amount.
module ALU
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] scrA,
  input  logic [XLEN-1:0] scrB,
  input  logic [2:0]      AluControl,
  output logic [XLEN-1:0] ALUresult
);

  // Select the result for the requested operation; unknown codes yield zero
  always_comb begin
    ALUresult = '0;
    case (AluControl)
      ALU_ADD:    ALUresult = scrA + scrB;
      ALU_SUB:    ALUresult = scrA - scrB;
      ALU_AND:    ALUresult = scrA & scrB;
      ALU_LSHIFT: ALUresult = scrA << scrB[4:0];
      default:    ALUresult = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier controller producing the low XLEN bits of
// opA_i * opB_i. One multiplier bit is consumed per cycle; the loop ends as
// soon as the remaining multiplier bits are all zero, so short multipliers
// finish early. The adder and the multiplicand shifter are two ALU instances
// with their operation tied off.
//
// Handshake: start_i is a request sampled only while IDLE (and only when
// flush_i is low); busy_o stays high from the accepting edge until the edge
// that leaves DONE, and done_o pulses for exactly the one DONE cycle, during
// which product_o/zero_o/sign_o are already valid. Those results are held
// until the next completion. flush_i aborts RUN without a done_o pulse.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] opA_i,
  input  logic [XLEN-1:0] opB_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] product_o,
  output logic            zero_o,
  output logic            sign_o,
  output seqStateT        dbgState
);

  seqStateT          state;
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   acc;
  logic [FLAG_W-1:0] flags;
  logic [XLEN-1:0]   addResult;
  logic [XLEN-1:0]   shlResult;

  // Constant shift amount of one for the multiplicand shifter
  localparam logic [XLEN-1:0] SHIFT_ONE = {{(XLEN-1){1'b0}}, 1'b1};

  // Accumulator adder: acc + mcand
  ALU #(.XLEN(XLEN)) u_alu_add (
    .scrA       (acc),
    .scrB       (mcand),
    .AluControl (ALU_ADD),
    .ALUresult  (addResult)
  );

  // Multiplicand shifter: mcand << 1
  ALU #(.XLEN(XLEN)) u_alu_shl (
    .scrA       (mcand),
    .scrB       (SHIFT_ONE),
    .AluControl (ALU_LSHIFT),
    .ALUresult  (shlResult)
  );

  // Sequencer FSM with all datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      product_o <= '0;
      flags     <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          // flush_i wins over a simultaneous request
          if (start_i && !flush_i) begin
            mcand  <= opA_i;
            mplier <= opB_i;
            acc    <= '0;
            busy_o <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (flush_i) begin
            // Abort: results and flags keep the last completed value
            busy_o <= 1'b0;
            state  <= IDLE;
          end else if (mplier == '0) begin
            // No multiplier bits left: publish the accumulator
            product_o   <= acc;
            flags[ZERO] <= (acc == '0);
            flags[SIGN] <= acc[XLEN-1];
            done_o      <= 1'b1;
            state       <= DONE;
          end else begin
            if (mplier[0]) begin
              acc <= addResult;
            end
            mcand  <= shlResult;
            mplier <= mplier >> 1;
          end
        end
        DONE: begin
          // Requests arriving here are dropped; the requester retries in IDLE
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign zero_o   = flags[ZERO];
  assign sign_o   = flags[SIGN];
  assign dbgState = state;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: directed corner cases followed by randomized
// operands, checked against an arithmetic reference model (product modulo
// 2^32, latency from the position of the multiplier's top set bit).
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  localparam int W = 32;
  localparam int MAX_WAIT = 40;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic         flush_i;
  logic [W-1:0] opA_i;
  logic [W-1:0] opB_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] product_o;
  logic         zero_o;
  logic         sign_o;
  seqStateT     dbgState;

  int passCnt  = 0;
  int checkCnt = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] lastProduct;

  alu_mul_sequencer #(.XLEN(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .flush_i   (flush_i),
    .opA_i     (opA_i),
    .opB_i     (opB_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .product_o (product_o),
    .zero_o    (zero_o),
    .sign_o    (sign_o),
    .dbgState  (dbgState)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checkCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference latency: 1 for a zero multiplier, else top set bit index + 2
  function automatic int refLatency(input logic [W-1:0] b);
    int msb;
    msb = -1;
    for (int i = 0; i < W; i++) if (b[i]) msb = i;
    return (msb < 0) ? 1 : msb + 2;
  endfunction

  // Drive one multiply and check result, latency, busy width and done pulse.
  // pokeRun > 0 pulses a stray start that many cycles into RUN; pokeDone
  // pulses a stray start during the DONE cycle.
  task automatic runMul(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int pokeRun, input bit pokeDone, input string tag);
    logic [W-1:0] expP;
    logic [W-1:0] modelP;
    int lat;
    int busyCnt;
    int expLat;
    modelP = a * b;
    exp_q.push_back(modelP);
    expLat = refLatency(b);
    @(negedge clk);
    opA_i = a; opB_i = b; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    lat = 0;
    busyCnt = 0;
    while (!done_o && lat < MAX_WAIT) begin
      if (busy_o) busyCnt++;
      if (pokeRun > 0 && lat == pokeRun) begin
        opA_i = $urandom; opB_i = $urandom; start_i = 1'b1;
      end
      @(negedge clk);
      start_i = 1'b0;
      lat++;
    end
    if (busy_o) busyCnt++;
    expP = exp_q.pop_front();
    check({tag, " latency"}, W'(lat), W'(expLat));
    if (lat < MAX_WAIT) begin
      check({tag, " product"}, product_o, expP);
      check({tag, " zero"}, W'(zero_o), W'(expP == 0));
      check({tag, " sign"}, W'(sign_o), W'(expP[W-1]));
      check({tag, " busy cycles"}, W'(busyCnt), W'(expLat + 1));
      if (pokeDone) begin
        opA_i = $urandom; opB_i = $urandom; start_i = 1'b1;
      end
      @(negedge clk);
      start_i = 1'b0;
      check({tag, " done pulse"}, W'(done_o), W'(0));
      check({tag, " busy low"}, W'(busy_o), W'(0));
      check({tag, " product held"}, product_o, expP);
      lastProduct = expP;
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int sawDone;

    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0; opA_i = '0; opB_i = '0;
    lastProduct = '0;
    repeat (3) @(negedge clk);
    check("reset product", product_o, 0);
    check("reset busy", W'(busy_o), 0);
    check("reset done", W'(done_o), 0);
    check("reset zero", W'(zero_o), 0);
    check("reset state", W'(dbgState), W'(IDLE));
    rst_n = 1'b1;

    // Directed cases
    runMul(32'd7, 32'd6, 0, 1'b0, "7x6");
    runMul(32'h1234, 32'h0, 0, 1'b0, "b zero");
    runMul(32'h0, 32'hFFFF_FFFF, 0, 1'b0, "a zero max lat");
    runMul(32'hFFFF_FFFF, 32'd3, 0, 1'b0, "neg one x3");
    runMul(32'h8000_0000, 32'd2, 0, 1'b0, "overflow wrap");
    runMul(32'd123, 32'd0000_0457, 3, 1'b1, "stray starts");

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    opA_i = 32'd5; opB_i = 32'hFF; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst mid product", product_o, 0);
    check("rst mid busy", W'(busy_o), 0);
    check("rst mid sign", W'(sign_o), 0);
    check("rst mid state", W'(dbgState), W'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    lastProduct = '0;
    runMul(32'd5, 32'hFF, 0, 1'b0, "after reset");

    // Flush at the second RUN step: no done, previous product held
    @(negedge clk);
    opA_i = 32'd9; opB_i = 32'hF0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush state", W'(dbgState), W'(IDLE));
    check("flush busy", W'(busy_o), 0);
    sawDone = 0;
    repeat (MAX_WAIT) begin
      @(negedge clk);
      if (done_o) sawDone++;
    end
    check("flush no done", W'(sawDone), 0);
    check("flush product held", product_o, lastProduct);

    // flush_i blocks a simultaneous start in IDLE
    opA_i = 32'd3; opB_i = 32'd3; start_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    check("flush blocks start", W'(busy_o), 0);
    runMul(32'd11, 32'd13, 0, 1'b0, "after flush");

    // Randomized operands with spread-out multiplier widths
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = W'($urandom) >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) rb = '0;
      runMul(ra, rb, 0, 1'b0, "rand");
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
